// File: rtl/mem_chk_pkg.sv
// Shared definitions for the memory interface checker: error bit positions and FSM states.
package mem_chk_pkg;

  localparam int NUM_ERR     = 7;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_UNSTABLE = 1;
  localparam int ERR_DROP    = 2;
  localparam int ERR_SPURIOUS = 3;
  localparam int ERR_RANGE   = 4;
  localparam int ERR_MISMATCH = 5;
  localparam int ERR_UNINIT  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LATE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_chk_shadow.sv
// Shadow copy of every completed in-range write, used to check read data on later reads.
module mem_chk_shadow #(
  parameter int IDX_W = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata_obs,
  output logic             mismatch,
  output logic             uninit
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (wr_en) vld_d[addr] = 1'b1;
  end

  // Data storage is never reset; the valid bits alone say whether an entry means anything.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  assign mismatch = rd_en && vld_q[addr] && (rdata_obs != mem_q[addr]);
  assign uninit   = rd_en && !vld_q[addr];

endmodule

// File: rtl/mem_chk_monitor.sv
// Passive protocol checker for the valid/ready memory port.
// Define MEM_CHK_SHADOW_EN to add the shadow RAM and read-data checks (MISMATCH/UNINIT).
module mem_chk_monitor
  import mem_chk_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int MAX_READY_LAT = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH-1:0]      rdata_o,
  input  logic                  valid_i,
  input  logic                  ready_o,
  output logic [NUM_ERR-1:0]    err_o,
  output logic [NUM_ERR-1:0]    err_pulse_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic [CNT_WIDTH-1:0]  rd_cnt_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                 state_q, state_d;
  logic [7:0]             lat_cnt_q, lat_cnt_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic                   unst_q, unst_d;
  logic [NUM_ERR-1:0]     err_q, err_d, err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [NUM_ERR-1:0]     fsm_err, det;
  logic                   hs, complete, in_range, req_diff;
  logic                   sh_mismatch, sh_uninit;

  assign hs       = valid_i && ready_o;
  assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH+1)'(DEPTH));
  // wdata only matters for stability when the latched request is a write.
  assign req_diff = (wr_rd_i != wr_q) || (addr_i != addr_q) || (wr_q && (wdata_i != wdata_q));

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unst_d    = unst_q;
    complete  = 1'b0;
    fsm_err   = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          complete = 1'b1;
        end else if (valid_i) begin
          wr_d    = wr_rd_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          unst_d  = 1'b0;
          if (MAX_READY_LAT == 0) begin
            fsm_err[ERR_TIMEOUT] = 1'b1;
            state_d = LATE;
          end else begin
            lat_cnt_d = 8'd1;
            state_d   = WAIT;
          end
        end else if (ready_o) begin
          fsm_err[ERR_SPURIOUS] = 1'b1;
        end
      end
      WAIT: begin
        if (valid_i && req_diff && !unst_q) begin
          fsm_err[ERR_UNSTABLE] = 1'b1;
          unst_d = 1'b1;
        end
        if (hs) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (!valid_i) begin
          fsm_err[ERR_DROP] = 1'b1;
          state_d = IDLE;
        end else if (lat_cnt_q == 8'(MAX_READY_LAT)) begin
          fsm_err[ERR_TIMEOUT] = 1'b1;
          state_d = LATE;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      LATE: begin
        if (hs) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (!valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_CHK_SHADOW_EN
  mem_chk_shadow #(
    .IDX_W (IDX_W),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_shadow (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en     (complete && wr_rd_i && in_range),
    .rd_en     (complete && !wr_rd_i && in_range),
    .addr      (addr_i[IDX_W-1:0]),
    .wdata     (wdata_i),
    .rdata_obs (rdata_o),
    .mismatch  (sh_mismatch),
    .uninit    (sh_uninit)
  );
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_o;
  assign sh_mismatch  = 1'b0;
  assign sh_uninit    = 1'b0;
`endif

  always_comb begin
    det               = fsm_err;
    det[ERR_RANGE]    = complete && !in_range;
    det[ERR_MISMATCH] = sh_mismatch;
    det[ERR_UNINIT]   = sh_uninit;
  end

  // Clear is applied first so anything detected in the same cycle survives it.
  always_comb begin
    err_pulse_d = det;
    err_d       = (clr_i ? '0 : err_q) | det;
    err_cnt_d   = clr_i ? '0 : err_cnt_q;
    if ((|det) && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + CNT_WIDTH'(1);
    wr_cnt_d    = clr_i ? '0 : wr_cnt_q;
    if (complete && wr_rd_i) wr_cnt_d = wr_cnt_d + CNT_WIDTH'(1);
    rd_cnt_d    = clr_i ? '0 : rd_cnt_q;
    if (complete && !wr_rd_i) rd_cnt_d = rd_cnt_d + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      unst_q      <= 1'b0;
      err_q       <= '0;
      err_pulse_q <= '0;
      err_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      unst_q      <= unst_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;

endmodule
